// File: rtl/enemy_pacer.sv
// enemy_pacer: per-enemy frame tick, move/bullet/shoot strobes, respawn X and difficulty level.
// Define ENEMY_PACER_BURST_EN to add a second, delayed shot after each FIRE at MAX_LEVEL.

module enemy_pacer #(
  parameter int          V_ACTIVE       = 480,
  parameter int          MOVE_DIV_INIT  = 8,
  parameter int          BULLET_DIV     = 1,
  parameter int          SHOOT_MIN      = 32,
  parameter int          SHOOT_MASK     = 63,
  parameter int          X_MIN          = 0,
  parameter int          X_MAX          = 608,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          LEVEL_UP_KILLS = 8,
  parameter int          MAX_LEVEL      = 3
`ifdef ENEMY_PACER_BURST_EN
  ,
  parameter int          BURST_GAP      = 8
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stop,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       killed,
  output logic       frame_tick,
  output logic       move_down,
  output logic       move_bullet,
  output logic       shoot,
  output logic [9:0] random_number_x,
  output logic [1:0] level
);

  localparam logic [9:0]  V_ACTIVE_W   = 10'(V_ACTIVE);
  localparam logic [7:0]  MOVE_DIV_W   = 8'(MOVE_DIV_INIT);
  localparam logic [7:0]  BULLET_LAST  = 8'(BULLET_DIV - 1);
  localparam logic [7:0]  SHOOT_MIN_W  = 8'(SHOOT_MIN);
  localparam logic [5:0]  SHOOT_MASK_W = 6'(SHOOT_MASK);
  localparam logic [9:0]  X_MIN_W      = 10'(X_MIN);
  localparam logic [9:0]  X_MAX_W      = 10'(X_MAX);
  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [7:0]  KILL_LAST    = 8'(LEVEL_UP_KILLS - 1);
  localparam logic [1:0]  MAX_LEVEL_W  = 2'(MAX_LEVEL);
`ifdef ENEMY_PACER_BURST_EN
  localparam logic [7:0]  BURST_GAP_W  = 8'(BURST_GAP);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIRE = 2'd2
`ifdef ENEMY_PACER_BURST_EN
    ,
    S_BURST = 2'd3
`endif
  } shoot_state_t;

  logic         frame_cond;
  logic         cond_q;
  logic         advance;
  logic [15:0]  lfsr;
  logic [15:0]  lfsr_next;
  logic         x_in_range;
  logic [7:0]   move_cnt;
  logic [7:0]   bullet_cnt;
  logic [7:0]   kill_cnt;
  logic [7:0]   div_shift;
  logic [7:0]   move_last;
  logic         move_hit;
  logic         bullet_hit;
  shoot_state_t state;
  shoot_state_t state_next;
  logic [7:0]   shoot_cnt;
  logic [7:0]   cnt_next;
  logic [7:0]   shoot_reload;
  logic         shoot_set;

  // Edge-detect the frame position so a slow pixel enable still yields one tick.
  assign frame_cond = (pix_x == 10'd0) && (pix_y == V_ACTIVE_W);
  assign advance    = frame_tick && !stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_q     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cond_q     <= frame_cond;
      frame_tick <= frame_cond && !cond_q;
    end
  end

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

  // Written as "> or ==" so a zero X_MIN does not become a constant-true compare.
  assign x_in_range = ((lfsr[9:0] > X_MIN_W) || (lfsr[9:0] == X_MIN_W)) &&
                      (lfsr[9:0] <= X_MAX_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr            <= LFSR_SEED;
      random_number_x <= X_MIN_W;
    end else begin
      lfsr <= lfsr_next;
      if (frame_tick && x_in_range) begin
        random_number_x <= lfsr[9:0];
      end
    end
  end

  always_comb begin
    div_shift = MOVE_DIV_W >> level;
    move_last = (div_shift == 8'd0) ? 8'd0 : div_shift - 8'd1;
  end

  assign move_hit   = (move_cnt >= move_last);
  assign bullet_hit = (bullet_cnt > BULLET_LAST) || (bullet_cnt == BULLET_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_cnt    <= 8'd0;
      bullet_cnt  <= 8'd0;
      move_down   <= 1'b0;
      move_bullet <= 1'b0;
    end else begin
      move_down   <= 1'b0;
      move_bullet <= 1'b0;
      if (advance) begin
        if (move_hit) begin
          move_down <= 1'b1;
          move_cnt  <= 8'd0;
        end else begin
          move_cnt  <= move_cnt + 8'd1;
        end
        if (bullet_hit) begin
          move_bullet <= 1'b1;
          bullet_cnt  <= 8'd0;
        end else begin
          bullet_cnt  <= bullet_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kill_cnt <= 8'd0;
      level    <= 2'd0;
    end else if (killed && !stop) begin
      if (kill_cnt == KILL_LAST) begin
        kill_cnt <= 8'd0;
        if (level < MAX_LEVEL_W) begin
          level <= level + 2'd1;
        end
      end else begin
        kill_cnt <= kill_cnt + 8'd1;
      end
    end
  end

  assign shoot_reload = SHOOT_MIN_W + {2'b00, lfsr[5:0] & SHOOT_MASK_W};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      shoot_cnt <= 8'd0;
      shoot     <= 1'b0;
    end else begin
      state     <= state_next;
      shoot_cnt <= cnt_next;
      shoot     <= shoot_set;
    end
  end

  // FIRE is a one-cycle state entered together with the registered shoot pulse.
  always_comb begin
    state_next = state;
    cnt_next   = shoot_cnt;
    shoot_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (advance) begin
          state_next = S_WAIT;
          cnt_next   = shoot_reload;
        end
      end
      S_WAIT: begin
        if (advance) begin
          if (shoot_cnt <= 8'd1) begin
            state_next = S_FIRE;
            cnt_next   = 8'd0;
            shoot_set  = 1'b1;
          end else begin
            cnt_next   = shoot_cnt - 8'd1;
          end
        end
      end
      S_FIRE: begin
`ifdef ENEMY_PACER_BURST_EN
        if (level == MAX_LEVEL_W) begin
          state_next = S_BURST;
          cnt_next   = BURST_GAP_W;
        end else begin
          state_next = S_WAIT;
          cnt_next   = shoot_reload;
        end
`else
        state_next = S_WAIT;
        cnt_next   = shoot_reload;
`endif
      end
`ifdef ENEMY_PACER_BURST_EN
      S_BURST: begin
        if (advance) begin
          if (shoot_cnt <= 8'd1) begin
            state_next = S_WAIT;
            cnt_next   = shoot_reload;
            shoot_set  = 1'b1;
          end else begin
            cnt_next   = shoot_cnt - 8'd1;
          end
        end
      end
`endif
      default: begin
        state_next = S_IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

endmodule
